store_unit: RTL and testbench

Store-side memory access unit for the RV32I multicycle core, the write counterpart of the load path that handles LB/LBU/LH/LHU/LW extraction and extension. During the memory-access state, the control FSM hands the unit one store (SB/SH/SW) with its effective address and rs2 value. The unit aligns the data to byte lanes, generates byte strobes, and runs a req/ack handshake to the data memory. Misaligned stores are either split into two word-aligned beats or flagged as a fault.

---
 rtl/store_unit_pkg.sv | 20 ++
 rtl/store_lane_align.sv | 47 ++++
 rtl/store_unit.sv | 173 +++++++++++++++++
 tb/tb_store_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_unit_pkg.sv
// Shared definitions for the RV32I store path: funct3 encodings (also used by
// the load path), store FSM states and byte-lane size masks.
package store_unit_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_FIN
    } state_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane alignment for a store: shifts the size mask and the
// sized data onto an 8-lane (two-word) window starting at the address offset.
module store_lane_align
    import store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [7:0]  m8,
    output logic [63:0] d64,
    output logic        crossing,
    output logic        misaligned
);

    logic [3:0]  mask;
    logic [31:0] sized;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        mask       = '0;
        sized      = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_SB: begin
                mask  = MASK_B;
                sized = {24'b0, data[7:0]};
            end
            F3_SH: begin
                mask       = MASK_H;
                sized      = {16'b0, data[15:0]};
                misaligned = off[0];
            end
            F3_SW: begin
                mask       = MASK_W;
                sized      = data;
                misaligned = (off != 2'b00);
            end
            default: ;
        endcase
    end

    // Unused upper bits of the source are zeroed above, so disabled lanes stay 0.
    assign m8       = {4'b0, mask} << off;
    assign d64      = {32'b0, sized} << {off, 3'b000};
    assign crossing = |m8[7:4];

endmodule

// File: rtl/store_unit.sv
// Store unit: aligns SB/SH/SW data to byte lanes and writes it through a
// req/ack memory port. STORE_MISALIGN_SPLIT_EN enables split word-crossing stores.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [2:0]        st_funct3,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              done,
    output logic              fault,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb
);

    state_e            state_q, state_d;
    logic              fault_q, fault_d;
    logic              req_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic [3:0]        wstrb_d;

    logic [7:0]        m8;
    logic [63:0]       d64;
    logic              crossing;
    logic              misaligned;
    logic              legal;
    logic              reject;

    store_lane_align u_align (
        .funct3     (st_funct3),
        .off        (st_addr[1:0]),
        .data       (st_data),
        .m8         (m8),
        .d64        (d64),
        .crossing   (crossing),
        .misaligned (misaligned)
    );

    assign legal = st_funct3 inside {F3_SB, F3_SH, F3_SW};

`ifdef STORE_MISALIGN_SPLIT_EN
    // Second-beat strobe/data are captured at accept so BEAT1 needs no realignment.
    logic        cross_q, cross_d;
    logic [3:0]  hi_strb_q, hi_strb_d;
    logic [31:0] hi_data_q, hi_data_d;
    logic        unused_align;
    assign unused_align = misaligned;
    assign reject       = !legal;
`else
    logic        unused_align;
    assign unused_align = ^{crossing, m8[7:4], d64[63:32]};
    assign reject       = !legal || misaligned;
`endif

    assign st_ready = (state_q == ST_IDLE);
    assign done     = (state_q == ST_FIN);
    assign fault    = done && fault_q;

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        req_d   = mem_req;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        wstrb_d = mem_wstrb;
`ifdef STORE_MISALIGN_SPLIT_EN
        cross_d   = cross_q;
        hi_strb_d = hi_strb_q;
        hi_data_d = hi_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (st_valid) begin
                    if (reject) begin
                        state_d = ST_FIN;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_BEAT0;
                        fault_d = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
                        wstrb_d = m8[3:0];
                        wdata_d = d64[31:0];
`ifdef STORE_MISALIGN_SPLIT_EN
                        cross_d   = crossing;
                        hi_strb_d = m8[7:4];
                        hi_data_d = d64[63:32];
`endif
                    end
                end
            end
            ST_BEAT0: begin
                if (mem_ack) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        state_d = ST_BEAT1;
                        addr_d  = mem_addr + ADDR_W'(4);
                        wstrb_d = hi_strb_q;
                        wdata_d = hi_data_q;
                    end else begin
                        state_d = ST_FIN;
                        req_d   = 1'b0;
                        addr_d  = '0;
                        wstrb_d = '0;
                        wdata_d = '0;
                    end
`else
                    state_d = ST_FIN;
                    req_d   = 1'b0;
                    addr_d  = '0;
                    wstrb_d = '0;
                    wdata_d = '0;
`endif
                end
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            ST_BEAT1: begin
                if (mem_ack) begin
                    state_d = ST_FIN;
                    req_d   = 1'b0;
                    addr_d  = '0;
                    wstrb_d = '0;
                    wdata_d = '0;
                end
            end
`endif
            ST_FIN: begin
                state_d = ST_IDLE;
                fault_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            fault_q   <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
            cross_q   <= 1'b0;
            hi_strb_q <= '0;
            hi_data_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            mem_req   <= req_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_wstrb <= wstrb_d;
`ifdef STORE_MISALIGN_SPLIT_EN
            cross_q   <= cross_d;
            hi_strb_q <= hi_strb_d;
            hi_data_q <= hi_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: expected beats and done/fault events are
// queued by the stimulus and popped by the memory responder and done monitor.
module tb_store_unit;
    import store_unit_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              st_valid = 1'b0;
    logic              st_ready;
    logic [2:0]        st_funct3 = '0;
    logic [ADDR_W-1:0] st_addr = '0;
    logic [31:0]       st_data = '0;
    logic              done;
    logic              fault;
    logic              mem_req;
    logic              mem_ack = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } beat_t;

    beat_t beat_q[$];
    bit    fault_q[$];
    beat_t cur_beat;
    bit    cur_fault;
    int    total = 0;
    int    bad = 0;
    int    ack_wait = 0;
    int    wait_cnt = 0;

    store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_funct3 (st_funct3),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .done      (done),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder + monitor: a beat is scored when ack is raised for it,
    // since it is then accepted at the following rising edge.
    always @(negedge clk) begin
        if (done) begin
            if (fault_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 fault=%b expected no done", fault);
            end else begin
                cur_fault = fault_q.pop_front();
                check("done_fault", {31'b0, fault}, {31'b0, cur_fault});
            end
        end else if (fault) begin
            total++;
            bad++;
            $display("FAIL fault_without_done: got fault=1 expected 0");
        end

        if (mem_ack) wait_cnt = 0;
        if (rst && mem_req) begin
            if (wait_cnt >= ack_wait) begin
                mem_ack = 1'b1;
                if (beat_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got addr=%h strb=%b data=%h expected none",
                             mem_addr, mem_wstrb, mem_wdata);
                end else begin
                    cur_beat = beat_q.pop_front();
                    check("beat_addr", mem_addr, cur_beat.addr);
                    check("beat_strb", {28'b0, mem_wstrb}, {28'b0, cur_beat.strb});
                    check("beat_data", mem_wdata, cur_beat.data);
                end
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Presents a store for one cycle (T); returns at the negedge of cycle T+1.
    task automatic start_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        check("ready_before_accept", {31'b0, st_ready}, 32'd1);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    // Counts cycles from the current one (counted as 1) until done is seen.
    task automatic wait_done(input string name, input int exp_lat);
        int lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        #12;
        check("rst_ready", {31'b0, st_ready}, 32'd1);
        check("rst_done",  {31'b0, done}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_req",   {31'b0, mem_req}, 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        beat_q.push_back('{32'h0000_0100, 4'b0010, 32'h0000_7800});
        fault_q.push_back(1'b0);
        start_store(F3_SB, 32'h0000_0101, 32'h1234_5678);
        wait_done("sb_101", 2);

        beat_q.push_back('{32'h0000_0100, 4'b1100, 32'hABCD_0000});
        fault_q.push_back(1'b0);
        start_store(F3_SH, 32'h0000_0102, 32'h0000_ABCD);
        wait_done("sh_102", 2);

        beat_q.push_back('{32'h0000_0100, 4'b1111, 32'hFFFF_FFFF});
        fault_q.push_back(1'b0);
        start_store(F3_SW, 32'h0000_0100, 32'hFFFF_FFFF);
        wait_done("sw_100", 2);

`ifdef STORE_MISALIGN_SPLIT_EN
        beat_q.push_back('{32'h0000_0100, 4'b1000, 32'h4400_0000});
        beat_q.push_back('{32'h0000_0104, 4'b0111, 32'h0011_2233});
        fault_q.push_back(1'b0);
        start_store(F3_SW, 32'h0000_0103, 32'h1122_3344);
        wait_done("sw_103_split", 3);

        beat_q.push_back('{32'h0000_0100, 4'b0110, 32'h00BE_EF00});
        fault_q.push_back(1'b0);
        start_store(F3_SH, 32'h0000_0101, 32'h0000_BEEF);
        wait_done("sh_101_inword", 2);

        beat_q.push_back('{32'hFFFF_FFFC, 4'b1100, 32'hBABE_0000});
        beat_q.push_back('{32'h0000_0000, 4'b0011, 32'h0000_CAFE});
        fault_q.push_back(1'b0);
        start_store(F3_SW, 32'hFFFF_FFFE, 32'hCAFE_BABE);
        wait_done("sw_wrap_split", 3);
`else
        fault_q.push_back(1'b1);
        start_store(F3_SW, 32'h0000_0103, 32'h1122_3344);
        wait_done("sw_103_fault", 1);

        fault_q.push_back(1'b1);
        start_store(F3_SH, 32'h0000_0101, 32'h0000_BEEF);
        wait_done("sh_101_fault", 1);

        fault_q.push_back(1'b1);
        start_store(F3_SW, 32'hFFFF_FFFE, 32'hCAFE_BABE);
        wait_done("sw_wrap_fault", 1);
`endif

        // Delayed ack: outputs held for 3 wait cycles, a busy st_valid is ignored.
        ack_wait = 3;
        beat_q.push_back('{32'h0000_0200, 4'b0001, 32'h0000_00A5});
        fault_q.push_back(1'b0);
        start_store(F3_SB, 32'h0000_0200, 32'h0000_00A5);
        for (int i = 0; i < 3; i++) begin
            check("hold_req",  {31'b0, mem_req}, 32'd1);
            check("hold_addr", mem_addr, 32'h0000_0200);
            check("hold_strb", {28'b0, mem_wstrb}, 32'd1);
            check("hold_data", mem_wdata, 32'h0000_00A5);
            if (i == 1) begin
                check("busy_not_ready", {31'b0, st_ready}, 32'd0);
                st_valid  = 1'b1;
                st_funct3 = F3_SW;
                st_addr   = 32'h0000_0300;
                st_data   = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            st_valid = 1'b0;
        end
        wait_done("sb_200_after_ack", 2);
        ack_wait = 0;

        fault_q.push_back(1'b1);
        start_store(3'b011, 32'h0000_0100, 32'h1111_1111);
        wait_done("illegal_f3", 1);

        beat_q.push_back('{32'h0000_0104, 4'b0001, 32'h0000_0099});
        fault_q.push_back(1'b0);
        start_store(F3_SB, 32'h0000_0104, 32'h0000_0099);
        wait_done("sb_after_fault", 2);

        // Reset while BEAT0 waits: req drops without a clock edge, no done follows.
        ack_wait = 1000;
        start_store(F3_SB, 32'h0000_0040, 32'h0000_0077);
        check("mid_req_before_rst", {31'b0, mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_req", {31'b0, mem_req}, 32'd0);
        check("rst_async_ready", {31'b0, st_ready}, 32'd1);
        @(negedge clk);
        rst      = 1'b1;
        ack_wait = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_ready", {31'b0, st_ready}, 32'd1);
            check("post_rst_done", {31'b0, done}, 32'd0);
        end

        check("beats_left", beat_q.size(), 32'd0);
        check("dones_left", fault_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
